// File: rtl/control_loop_pid_math.sv
// Sequential PID math: one shared Booth multiplier and saturating Q-format arithmetic.
// Define CONTROL_LOOP_DERIV_EN to add the derivative term (cl_D, e_prev2 ports and CALC_ED state).

module boothmul #(
  parameter int A1_LEN    = 64,
  parameter int A2_LEN    = 64,
  parameter int A2LEN_SIZ = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arm,
  input  logic signed [A1_LEN-1:0]         a1,
  input  logic signed [A2_LEN-1:0]         a2,
  output logic signed [A1_LEN+A2_LEN-1:0]  outn,
  output logic                             fin
);
  localparam int PW = A1_LEN + A2_LEN + 2;

  logic signed [PW-1:0]     p;
  logic [A2LEN_SIZ-1:0]     cnt;
  logic                     busy;
  logic signed [A1_LEN:0]   a1x;
  logic signed [A1_LEN:0]   upper;
  logic signed [A1_LEN:0]   upper_nx;

  // Upper accumulator carries one guard bit so adding the most negative a1 cannot overflow
  always_comb begin
    a1x      = {a1[A1_LEN-1], a1};
    upper    = p[PW-1 -: A1_LEN+1];
    upper_nx = upper;
    case (p[1:0])
      2'b01:   upper_nx = upper + a1x;
      2'b10:   upper_nx = upper - a1x;
      default: upper_nx = upper;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      fin  <= 1'b0;
    end else if (busy) begin
      p <= $signed({upper_nx, p[A2_LEN:0]}) >>> 1;
      if (cnt == A2LEN_SIZ'(A2_LEN - 1)) begin
        busy <= 1'b0;
        fin  <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (fin) begin
      if (!arm) fin <= 1'b0;
    end else if (arm) begin
      p    <= {{(A1_LEN+1){1'b0}}, a2, 1'b0};
      cnt  <= '0;
      busy <= 1'b1;
    end
  end

  assign outn = p[A1_LEN+A2_LEN:1];
endmodule

module control_loop_pid_math #(
  parameter int CONSTS_WHOLE    = 21,
  parameter int CONSTS_FRAC     = 43,
  parameter int CONSTS_SIZ      = 7,
  parameter int ADC_WID         = 18,
  parameter int DAC_WID         = 20,
  parameter int CYCLE_COUNT_WID = 18,
  parameter logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0] SEC_PER_CYCLE = 64'sd87961,
  parameter logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0] ADC_TO_DAC    = 64'sd2251799813685
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        arm,
  output logic                                        finished,
  input  logic signed [ADC_WID-1:0]                   setpt,
  input  logic signed [ADC_WID-1:0]                   measured,
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0]  cl_P,
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0]  cl_I,
`ifdef CONTROL_LOOP_DERIV_EN
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0]  cl_D,
  input  logic signed [DAC_WID:0]                     e_prev2,
`endif
  input  logic [CYCLE_COUNT_WID-1:0]                  cycles,
  input  logic signed [DAC_WID:0]                     e_prev,
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0]  adjval_prev,
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0]  adj_min,
  input  logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0]  adj_max,
  output logic signed [DAC_WID:0]                     e_cur,
  output logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0]  adj_val,
  output logic                                        clamped
);
  localparam int CONSTS_WID = CONSTS_WHOLE + CONSTS_FRAC;
  localparam int E_WID      = DAC_WID + 1;
  localparam int PROD_WID   = 2 * CONSTS_WID;
  localparam logic signed [CONSTS_WID-1:0] Q_MAX = {1'b0, {(CONSTS_WID-1){1'b1}}};
  localparam logic signed [CONSTS_WID-1:0] Q_MIN = {1'b1, {(CONSTS_WID-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, CALC_E, CALC_DT, CALC_IDT, CALC_EI, CALC_EP,
`ifdef CONTROL_LOOP_DERIV_EN
    CALC_ED,
`endif
    SUM, CLAMP, DONE
  } state_t;

  function automatic logic signed [CONSTS_WID-1:0] sat_add(
    input logic signed [CONSTS_WID-1:0] a, input logic signed [CONSTS_WID-1:0] b);
    logic signed [CONSTS_WID:0] s;
    s = {a[CONSTS_WID-1], a} + {b[CONSTS_WID-1], b};
    if (s[CONSTS_WID] != s[CONSTS_WID-1]) return s[CONSTS_WID] ? Q_MIN : Q_MAX;
    return s[CONSTS_WID-1:0];
  endfunction

  function automatic logic signed [CONSTS_WID-1:0] sat_sub(
    input logic signed [CONSTS_WID-1:0] a, input logic signed [CONSTS_WID-1:0] b);
    logic signed [CONSTS_WID:0] s;
    s = {a[CONSTS_WID-1], a} - {b[CONSTS_WID-1], b};
    if (s[CONSTS_WID] != s[CONSTS_WID-1]) return s[CONSTS_WID] ? Q_MIN : Q_MAX;
    return s[CONSTS_WID-1:0];
  endfunction

  // Drop the extra fractional bits of a Q*Q product, then saturate back to Q width
  function automatic logic signed [CONSTS_WID-1:0] sat_prod(input logic signed [PROD_WID-1:0] p);
    logic signed [PROD_WID-1:0]        sh;
    logic [PROD_WID-CONSTS_WID:0]      hi;
    sh = p >>> CONSTS_FRAC;
    hi = sh[PROD_WID-1:CONSTS_WID-1];
    if (&hi || ~|hi) return sh[CONSTS_WID-1:0];
    return sh[PROD_WID-1] ? Q_MIN : Q_MAX;
  endfunction

  function automatic logic signed [E_WID-1:0] to_e(input logic signed [CONSTS_WID-1:0] q);
    logic signed [CONSTS_WID-1:0]  ip;
    logic [CONSTS_WID-E_WID:0]     hi;
    ip = q >>> CONSTS_FRAC;
    hi = ip[CONSTS_WID-1:E_WID-1];
    if (&hi || ~|hi) return ip[E_WID-1:0];
    return ip[CONSTS_WID-1] ? {1'b1, {(E_WID-1){1'b0}}} : {1'b0, {(E_WID-1){1'b1}}};
  endfunction

  state_t                       state, next_st;
  logic                         is_calc;
  logic                         mul_arm, mul_fin, mul_done;
  logic signed [CONSTS_WID-1:0] mul_a, mul_b, prod_q;
  logic signed [PROD_WID-1:0]   mul_out;
  logic signed [CONSTS_WID-1:0] dt_r, idt_r, pei_r, pep_r, sum_r, sum_nx;
  logic signed [ADC_WID:0]      diff;
  logic signed [CONSTS_WID-1:0] diff_q, cycles_q, e_cur_q, e_prev_q;
`ifdef CONTROL_LOOP_DERIV_EN
  logic signed [CONSTS_WID-1:0] ped_r, e_prev2_q, dd_q;
`endif

  boothmul #(
    .A1_LEN    (CONSTS_WID),
    .A2_LEN    (CONSTS_WID),
    .A2LEN_SIZ (CONSTS_SIZ)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .arm  (mul_arm),
    .a1   (mul_a),
    .a2   (mul_b),
    .outn (mul_out),
    .fin  (mul_fin)
  );

  // Integer-valued operands are promoted to Q format before entering the multiplier
  always_comb begin
    diff     = {setpt[ADC_WID-1], setpt} - {measured[ADC_WID-1], measured};
    diff_q   = CONSTS_WID'(diff) <<< CONSTS_FRAC;
    cycles_q = CONSTS_WID'(cycles) << CONSTS_FRAC;
    e_cur_q  = CONSTS_WID'(e_cur) <<< CONSTS_FRAC;
    e_prev_q = CONSTS_WID'(e_prev) <<< CONSTS_FRAC;
`ifdef CONTROL_LOOP_DERIV_EN
    e_prev2_q = CONSTS_WID'(e_prev2) <<< CONSTS_FRAC;
    dd_q      = sat_add(sat_sub(sat_sub(e_cur_q, e_prev_q), e_prev_q), e_prev2_q);
`endif
    mul_done = mul_arm && mul_fin;
    prod_q   = sat_prod(mul_out);
  end

  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    next_st = IDLE;
    is_calc = 1'b0;
    case (state)
      CALC_E:   begin mul_a = diff_q;        mul_b = ADC_TO_DAC; next_st = CALC_DT;  is_calc = 1'b1; end
      CALC_DT:  begin mul_a = SEC_PER_CYCLE; mul_b = cycles_q;   next_st = CALC_IDT; is_calc = 1'b1; end
      CALC_IDT: begin mul_a = cl_I;          mul_b = dt_r;       next_st = CALC_EI;  is_calc = 1'b1; end
      CALC_EI:  begin mul_a = sat_add(cl_P, idt_r); mul_b = e_cur_q; next_st = CALC_EP; is_calc = 1'b1; end
`ifdef CONTROL_LOOP_DERIV_EN
      CALC_EP:  begin mul_a = cl_P;          mul_b = e_prev_q;   next_st = CALC_ED;  is_calc = 1'b1; end
      CALC_ED:  begin mul_a = cl_D;          mul_b = dd_q;       next_st = SUM;      is_calc = 1'b1; end
`else
      CALC_EP:  begin mul_a = cl_P;          mul_b = e_prev_q;   next_st = SUM;      is_calc = 1'b1; end
`endif
      default:  begin mul_a = '0; mul_b = '0; next_st = IDLE; is_calc = 1'b0; end
    endcase
  end

  always_comb begin
    sum_nx = sat_sub(sat_add(adjval_prev, pei_r), pep_r);
`ifdef CONTROL_LOOP_DERIV_EN
    sum_nx = sat_add(sum_nx, ped_r);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      finished <= 1'b0;
      clamped  <= 1'b0;
      e_cur    <= '0;
      adj_val  <= '0;
      mul_arm  <= 1'b0;
      dt_r     <= '0;
      idt_r    <= '0;
      pei_r    <= '0;
      pep_r    <= '0;
      sum_r    <= '0;
`ifdef CONTROL_LOOP_DERIV_EN
      ped_r    <= '0;
`endif
    end else if (is_calc) begin
      // Multiplier arm drops after each product and re-rises only once its fin has cleared
      if (mul_done) begin
        mul_arm <= 1'b0;
        state   <= next_st;
        case (state)
          CALC_E:   e_cur <= to_e(prod_q);
          CALC_DT:  dt_r  <= prod_q;
          CALC_IDT: idt_r <= prod_q;
          CALC_EI:  pei_r <= prod_q;
          CALC_EP:  pep_r <= prod_q;
`ifdef CONTROL_LOOP_DERIV_EN
          CALC_ED:  ped_r <= prod_q;
`endif
          default:  ;
        endcase
      end else if (!mul_arm && !mul_fin) begin
        mul_arm <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: if (arm) state <= CALC_E;
        SUM: begin
          sum_r <= sum_nx;
          state <= CLAMP;
        end
        CLAMP: begin
          if (adj_min > adj_max) begin
            adj_val <= adj_min;
            clamped <= 1'b1;
          end else if (sum_r < adj_min) begin
            adj_val <= adj_min;
            clamped <= 1'b1;
          end else if (sum_r > adj_max) begin
            adj_val <= adj_max;
            clamped <= 1'b1;
          end else begin
            adj_val <= sum_r;
            clamped <= 1'b0;
          end
          finished <= 1'b1;
          state    <= DONE;
        end
        DONE: if (!arm) begin
          finished <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_control_loop_pid_math.sv
// Scoreboard bench for control_loop_pid_math: directed and random runs against a saturating Q-format model.
module tb_control_loop_pid_math;
  localparam int FR = 43;
  localparam int W  = 64;
  localparam int AW = 18;
  localparam int E  = 21;
  localparam int CW = 18;
  typedef logic signed [W-1:0]   q_t;
  typedef logic signed [W*2+3:0] wide_t;
  localparam q_t ONE  = 64'sh0000_0800_0000_0000;
  localparam q_t QMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam q_t QMIN = 64'sh8000_0000_0000_0000;

  typedef struct {
    longint e;
    q_t     adj;
    logic   cl;
  } exp_t;

  logic clk = 1'b0;
  logic rst, arm, finished, clamped;
  logic signed [AW-1:0] setpt, measured;
  q_t cl_P, cl_I, cl_D, adjval_prev, adj_min, adj_max, adj_val;
  logic [CW-1:0] cycles;
  logic signed [E-1:0] e_prev, e_prev2, e_cur;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic fin_q = 1'b0;

  control_loop_pid_math #(
    .SEC_PER_CYCLE (ONE),
    .ADC_TO_DAC    (ONE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .finished    (finished),
    .setpt       (setpt),
    .measured    (measured),
    .cl_P        (cl_P),
    .cl_I        (cl_I),
`ifdef CONTROL_LOOP_DERIV_EN
    .cl_D        (cl_D),
    .e_prev2     (e_prev2),
`endif
    .cycles      (cycles),
    .e_prev      (e_prev),
    .adjval_prev (adjval_prev),
    .adj_min     (adj_min),
    .adj_max     (adj_max),
    .e_cur       (e_cur),
    .adj_val     (adj_val),
    .clamped     (clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic q_t satq(input wide_t x);
    if (x > wide_t'(QMAX)) return QMAX;
    if (x < wide_t'(QMIN)) return QMIN;
    return q_t'(x);
  endfunction
  function automatic q_t addq(input q_t a, input q_t b);
    return satq(wide_t'(a) + wide_t'(b));
  endfunction
  function automatic q_t subq(input q_t a, input q_t b);
    return satq(wide_t'(a) - wide_t'(b));
  endfunction
  function automatic q_t mulq(input q_t a, input q_t b);
    wide_t p;
    p = wide_t'(a) * wide_t'(b);
    return satq(p >>> FR);
  endfunction
  function automatic q_t iq(input longint v);
    return q_t'(v) <<< FR;
  endfunction

  // Reference: e = floor(diff*scale), then the saturating PID sum and clamp
  function automatic exp_t model();
    exp_t r;
    longint ei;
    q_t dt, idt, acc, ecq;
    ei = longint'(mulq(iq(longint'(setpt) - longint'(measured)), ONE) >>> FR);
    if (ei > 2**20 - 1) ei = 2**20 - 1;
    if (ei < -(2**20)) ei = -(2**20);
    r.e = ei;
    ecq = iq(ei);
    dt  = mulq(ONE, iq(longint'(cycles)));
    idt = mulq(cl_I, dt);
    acc = addq(adjval_prev, mulq(addq(cl_P, idt), ecq));
    acc = subq(acc, mulq(cl_P, iq(longint'(e_prev))));
`ifdef CONTROL_LOOP_DERIV_EN
    acc = addq(acc, mulq(cl_D, addq(subq(subq(ecq, iq(longint'(e_prev))), iq(longint'(e_prev))),
                                    iq(longint'(e_prev2)))));
`endif
    if (adj_min > adj_max)  begin r.adj = adj_min; r.cl = 1'b1; end
    else if (acc < adj_min) begin r.adj = adj_min; r.cl = 1'b1; end
    else if (acc > adj_max) begin r.adj = adj_max; r.cl = 1'b1; end
    else                    begin r.adj = acc;     r.cl = 1'b0; end
    return r;
  endfunction

  function automatic q_t rq(input int mag);
    q_t f;
    f = {$urandom(), $urandom()};
    f = f & ((q_t'(1) <<< FR) - 1);
    return iq(longint'($urandom_range(0, 2 * mag)) - mag) + f;
  endfunction

  always @(negedge clk) begin
    if (finished && !fin_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_finish", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("e_cur", longint'(e_cur), x.e);
        chk("adj_val", longint'(adj_val), longint'(x.adj));
        chk("clamped", longint'(clamped), longint'(x.cl));
      end
    end
    fin_q = finished;
  end

  task automatic wait_fin();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (finished) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("finish_timeout", 0, 1);
  endtask

  task automatic do_txn(input int hold);
    sb.push_back(model());
    arm = 1'b1;
    wait_fin();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("finished_held", longint'(finished), 1);
    end
    arm = 1'b0;
    @(negedge clk);
    chk("finished_drop", longint'(finished), 0);
  endtask

  task automatic base();
    setpt = 18'sd100; measured = 18'sd40; cl_P = ONE; cl_I = '0; cl_D = '0;
    cycles = '0; e_prev = '0; e_prev2 = '0; adjval_prev = '0;
    adj_min = -iq(1000); adj_max = iq(1000);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0;
    base();
    repeat (3) @(negedge clk);
    chk("rst_finished", longint'(finished), 0);
    chk("rst_e_cur", longint'(e_cur), 0);
    chk("rst_adj_val", longint'(adj_val), 0);
    chk("rst_clamped", longint'(clamped), 0);
    rst = 1'b0;
    @(negedge clk);

    base(); do_txn(0);
    chk("p_only_adj", longint'(adj_val), longint'(iq(60)));
    base(); cl_P = '0; cl_I = ONE >>> 1; cycles = 4; do_txn(0);
    chk("i_term_adj", longint'(adj_val), longint'(iq(120)));
    base(); cl_P = '0; cl_I = ONE >>> 1; cycles = 0; do_txn(0);
    base(); adj_max = iq(50); do_txn(0);
    chk("clamp_hi_flag", longint'(clamped), 1);
    base(); adjval_prev = QMAX; adj_max = QMAX; do_txn(0);
    base(); adj_min = iq(100); adj_max = -iq(100); do_txn(0);
`ifdef CONTROL_LOOP_DERIV_EN
    base(); cl_P = '0; cl_D = ONE; setpt = 18'sd60; measured = 18'sd0;
    e_prev = 21'sd20; e_prev2 = 21'sd10; do_txn(0);
    chk("d_term_adj", longint'(adj_val), longint'(iq(30)));
`endif
    base(); setpt = 18'sd5; measured = 18'sd7; do_txn(10);

    // Abort in the middle of the run, then restart with arm held across reset release
    base(); setpt = 18'sd300; measured = -18'sd20;
    arm = 1'b1;
    repeat (310) @(negedge clk);
    chk("mid_e_cur", longint'(e_cur), 320);
    chk("mid_finished", longint'(finished), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_e_cur", longint'(e_cur), 0);
    chk("abort_adj_val", longint'(adj_val), 0);
    chk("abort_finished", longint'(finished), 0);
    sb.push_back(model());
    rst = 1'b0;
    wait_fin();
    arm = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      setpt       = AW'($urandom_range(0, 2**18 - 1) - 2**17);
      measured    = AW'($urandom_range(0, 2**18 - 1) - 2**17);
      cl_P        = rq(8);
      cl_I        = rq(2);
      cl_D        = rq(2);
      cycles      = CW'($urandom_range(0, 15));
      e_prev      = E'($urandom_range(0, 2**19) - 2**18);
      e_prev2     = E'($urandom_range(0, 2**19) - 2**18);
      adjval_prev = rq(100000);
      adj_min     = -iq(longint'($urandom_range(0, 2**19)));
      adj_max     = iq(longint'($urandom_range(0, 2**19)));
      if (n % 7 == 3) adj_min = adj_max + ONE;
      do_txn($urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
